// File: rtl/mux_key_pkg.sv
// mux_key_pkg
// Shared definitions for the programmable key/data lookup CAM family.
//   idx_width()     : index width for an entry count, never less than 1 bit
//   MIN_ENTRIES     : smallest supported table size
//   DEF_*           : default geometry shared by the top and the match stage
package mux_key_pkg;

    localparam int MIN_ENTRIES  = 2;
    localparam int DEF_NR_KEY   = 8;
    localparam int DEF_KEY_LEN  = 12;
    localparam int DEF_DATA_LEN = 32;

    // $clog2(1) is 0, which would give a zero-width index; clamp to 1.
    function automatic int idx_width(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_key_match.sv
// mux_key_match
// Purely combinational match stage: compares one key against every entry and
// returns the lowest-index valid match. Data is selected, never OR-combined.
// Ports:
//   i_key    lookup key
//   i_valid  per-entry valid bits
//   i_keys   per-entry stored keys
//   i_data   per-entry stored data
//   o_hit    some valid entry matched
//   o_idx    lowest matching index (0 on miss)
//   o_data   data of that entry (0 on miss)
module mux_key_match
    import mux_key_pkg::*;
#(
    parameter  int NR_KEY   = DEF_NR_KEY,
    parameter  int KEY_LEN  = DEF_KEY_LEN,
    parameter  int DATA_LEN = DEF_DATA_LEN,
    localparam int IDX_LEN  = idx_width(NR_KEY)
) (
    input  logic [KEY_LEN-1:0]               i_key,
    input  logic [NR_KEY-1:0]                i_valid,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]   i_keys,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0]  i_data,
    output logic                             o_hit,
    output logic [IDX_LEN-1:0]               o_idx,
    output logic [DATA_LEN-1:0]              o_data
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_data = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_keys[i] == i_key)) begin
                o_hit  = 1'b1;
                o_idx  = IDX_LEN'(i);
                o_data = i_data[i];
            end
        end
    end

endmodule

// File: rtl/mux_key_cam.sv
// mux_key_cam
// Runtime-programmable key/data lookup table with a valid/ready lookup port
// and a registered, one-cycle-latency response.
// Ports:
//   clk, rst                  clock, async active-high reset
//   wr_en/wr_idx/wr_key/
//   wr_data/wr_clr            entry write (or invalidate when wr_clr=1)
//   flush                     invalidate every entry
//   lk_valid/lk_ready/lk_key  lookup request handshake
//   default_out               miss data, captured with the request
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_hit/rsp_idx  response payload
//   occupancy                 running count of valid entries
module mux_key_cam
    import mux_key_pkg::*;
#(
    parameter  int NR_KEY      = DEF_NR_KEY,
    parameter  int KEY_LEN     = DEF_KEY_LEN,
    parameter  int DATA_LEN    = DEF_DATA_LEN,
    parameter  bit HAS_DEFAULT = 1'b1,
    localparam int IDX_LEN     = idx_width(NR_KEY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_LEN-1:0]   wr_idx,
    input  logic [KEY_LEN-1:0]   wr_key,
    input  logic [DATA_LEN-1:0]  wr_data,
    input  logic                 wr_clr,
    input  logic                 flush,
    input  logic                 lk_valid,
    output logic                 lk_ready,
    input  logic [KEY_LEN-1:0]   lk_key,
    input  logic [DATA_LEN-1:0]  default_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_LEN-1:0]  rsp_data,
    output logic                 rsp_hit,
    output logic [IDX_LEN-1:0]   rsp_idx,
    output logic [IDX_LEN:0]     occupancy
);

    logic [NR_KEY-1:0]                r_valid;
    logic [NR_KEY-1:0]                w_valid_nxt;
    logic [NR_KEY-1:0][KEY_LEN-1:0]   r_key;
    logic [NR_KEY-1:0][DATA_LEN-1:0]  r_data;
    logic [IDX_LEN:0]                 r_occ;
    logic [IDX_LEN:0]                 w_occ_nxt;

    logic                             r_rsp_valid;
    logic [DATA_LEN-1:0]              r_rsp_data;
    logic                             r_rsp_hit;
    logic [IDX_LEN-1:0]               r_rsp_idx;

    logic                             w_wr_act;
    logic                             w_accept;
    logic                             w_hit;
    logic [IDX_LEN-1:0]               w_idx;
    logic [DATA_LEN-1:0]              w_hit_data;
    logic [DATA_LEN-1:0]              w_miss_data;

    // Out-of-range indices (non power-of-two NR_KEY) are dropped.
    assign w_wr_act = wr_en && ({1'b0, wr_idx} < (IDX_LEN+1)'(NR_KEY));

    // Flush clears first, so a same-cycle write survives it.
    always_comb begin
        w_valid_nxt = flush ? '0 : r_valid;
        if (w_wr_act) w_valid_nxt[wr_idx] = !wr_clr;
    end

    // Counter tracks the net valid-bit change of the single write port.
    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = (w_wr_act && !wr_clr) ? (IDX_LEN+1)'(1) : '0;
        end else if (w_wr_act) begin
            if (!wr_clr && !r_valid[wr_idx])
                w_occ_nxt = r_occ + (IDX_LEN+1)'(1);
            else if (wr_clr && r_valid[wr_idx])
                w_occ_nxt = r_occ - (IDX_LEN+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    // Key/data storage is deliberately not reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (w_wr_act && !wr_clr) begin
            r_key[wr_idx]  <= wr_key;
            r_data[wr_idx] <= wr_data;
        end
    end

    // Lookup sees the pre-edge table, so same-cycle writes/flushes are not visible.
    mux_key_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_match (
        .i_key   (lk_key),
        .i_valid (r_valid),
        .i_keys  (r_key),
        .i_data  (r_data),
        .o_hit   (w_hit),
        .o_idx   (w_idx),
        .o_data  (w_hit_data)
    );

    assign w_miss_data = HAS_DEFAULT ? default_out : '0;
    assign lk_ready    = !r_rsp_valid || rsp_ready;
    assign w_accept    = lk_valid && lk_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_hit ? w_hit_data : w_miss_data;
            r_rsp_hit   <= w_hit;
            r_rsp_idx   <= w_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_idx   = r_rsp_idx;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_mux_key_cam.sv
module tb_mux_key_cam;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [11:0] wr_key;
    logic [31:0] wr_data;
    logic        wr_clr;
    logic        flush;
    logic        lk_valid;
    logic        lk_ready;
    logic [11:0] lk_key;
    logic [31:0] default_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_hit;
    logic [2:0]  rsp_idx;
    logic [3:0]  occupancy;

    always #5 clk = ~clk;

    mux_key_cam #(
        .NR_KEY      (8),
        .KEY_LEN     (12),
        .DATA_LEN    (32),
        .HAS_DEFAULT (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_key      (wr_key),
        .wr_data     (wr_data),
        .wr_clr      (wr_clr),
        .flush       (flush),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_key      (lk_key),
        .default_out (default_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_hit     (rsp_hit),
        .rsp_idx     (rsp_idx),
        .occupancy   (occupancy)
    );

    typedef struct {
        logic        wr_en;
        logic        wr_clr;
        logic [2:0]  wr_idx;
        logic [11:0] wr_key;
        logic [31:0] wr_data;
        logic        flush;
        logic        lk_valid;
        logic [11:0] lk_key;
        logic [31:0] dflt;
        logic        rsp_ready;
        logic        exp_hit;
        logic [2:0]  exp_idx;
        logic [31:0] exp_data;
        logic [3:0]  exp_occ;
    } row_t;

    typedef struct {
        logic        hit;
        logic [2:0]  idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    row_t tbl[17];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic row_t mk_idle(input logic [3:0] occ);
        row_t r;
        r = '{default: '0};
        r.rsp_ready = 1'b1;
        r.dflt      = 32'hDEAD_BEEF;
        r.exp_occ   = occ;
        return r;
    endfunction

    function automatic row_t mk_wr(input logic [2:0] idx, input logic [11:0] key,
                                   input logic [31:0] data, input logic [3:0] occ);
        row_t r;
        r = mk_idle(occ);
        r.wr_en   = 1'b1;
        r.wr_idx  = idx;
        r.wr_key  = key;
        r.wr_data = data;
        return r;
    endfunction

    function automatic row_t mk_lk(input logic [11:0] key, input logic hit, input logic [2:0] idx,
                                   input logic [31:0] data, input logic [3:0] occ);
        row_t r;
        r = mk_idle(occ);
        r.lk_valid = 1'b1;
        r.lk_key   = key;
        r.exp_hit  = hit;
        r.exp_idx  = idx;
        r.exp_data = data;
        return r;
    endfunction

    // Drive one cycle at the falling edge, check just after, then advance.
    task automatic apply(input row_t r);
        logic exp_ready;
        rsp_t e;
        wr_en       = r.wr_en;
        wr_clr      = r.wr_clr;
        wr_idx      = r.wr_idx;
        wr_key      = r.wr_key;
        wr_data     = r.wr_data;
        flush       = r.flush;
        lk_valid    = r.lk_valid;
        lk_key      = r.lk_key;
        default_out = r.dflt;
        rsp_ready   = r.rsp_ready;
        #1;
        chk("occupancy", 32'(occupancy), 32'(r.exp_occ));
        exp_ready = (sb.size() == 0) || r.rsp_ready;
        chk("lk_ready", 32'(lk_ready), 32'(exp_ready));
        if (sb.size() != 0) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hit", 32'(rsp_hit), 32'(sb[0].hit));
            chk("rsp_idx", 32'(rsp_idx), 32'(sb[0].idx));
            chk("rsp_data", rsp_data, sb[0].data);
            if (r.rsp_ready) void'(sb.pop_front());
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        if (r.lk_valid && exp_ready) begin
            e.hit  = r.exp_hit;
            e.idx  = r.exp_idx;
            e.data = r.exp_data;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t r;
        rst = 1'b1;
        wr_en = 0; wr_clr = 0; wr_idx = 0; wr_key = 0; wr_data = 0; flush = 0;
        lk_valid = 0; lk_key = 0; default_out = 0; rsp_ready = 0;

        @(negedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("reset_rsp_idx", 32'(rsp_idx), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_lk_ready", 32'(lk_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = mk_lk(12'h123, 1'b0, 3'd0, 32'hDEAD_BEEF, 4'd0);
        tbl[1]  = mk_wr(3'd3, 12'h123, 32'hA5A5_0003, 4'd0);
        tbl[2]  = mk_lk(12'h123, 1'b1, 3'd3, 32'hA5A5_0003, 4'd1);
        tbl[3]  = mk_wr(3'd1, 12'h0F0, 32'h11, 4'd1);
        tbl[4]  = mk_wr(3'd5, 12'h0F0, 32'h55, 4'd2);
        tbl[5]  = mk_lk(12'h0F0, 1'b1, 3'd1, 32'h11, 4'd3);
        tbl[6]  = mk_wr(3'd1, 12'h0F0, 32'h999, 4'd3);
        tbl[6].wr_clr = 1'b1;
        tbl[7]  = mk_lk(12'h0F0, 1'b1, 3'd5, 32'h55, 4'd2);
        tbl[8]  = mk_lk(12'h777, 1'b0, 3'd0, 32'h0BAD_F00D, 4'd2);
        tbl[8].dflt = 32'h0BAD_F00D;
        tbl[8].wr_en = 1'b1; tbl[8].wr_idx = 3'd2; tbl[8].wr_key = 12'h777; tbl[8].wr_data = 32'h22;
        tbl[9]  = mk_lk(12'h777, 1'b1, 3'd2, 32'h22, 4'd3);
        tbl[10] = mk_wr(3'd3, 12'h456, 32'h33, 4'd3);
        tbl[11] = mk_lk(12'h123, 1'b0, 3'd0, 32'h1234_5678, 4'd3);
        tbl[11].dflt = 32'h1234_5678;
        tbl[12] = mk_lk(12'h456, 1'b1, 3'd3, 32'h33, 4'd3);
        tbl[13] = mk_lk(12'h0F0, 1'b1, 3'd5, 32'h55, 4'd3);
        tbl[13].wr_en = 1'b1; tbl[13].wr_clr = 1'b1; tbl[13].wr_idx = 3'd0;
        tbl[14] = mk_lk(12'h777, 1'b1, 3'd2, 32'h22, 4'd3);
        tbl[14].flush = 1'b1;
        tbl[15] = mk_lk(12'h777, 1'b0, 3'd0, 32'hDEAD_BEEF, 4'd0);
        tbl[16] = mk_idle(4'd0);

        for (int i = 0; i < 17; i++) apply(tbl[i]);

        // Stalled response: flush and key changes must not disturb it.
        apply(mk_wr(3'd4, 12'hABC, 32'h44, 4'd0));
        apply(mk_lk(12'hABC, 1'b1, 3'd4, 32'h44, 4'd1));
        for (int k = 0; k < 4; k++) begin
            r = mk_lk(12'(256 + k), 1'b0, 3'd0, 32'h0, (k == 0) ? 4'd1 : 4'd0);
            r.rsp_ready = 1'b0;
            r.dflt      = 32'(k);
            r.flush     = (k == 0);
            apply(r);
        end
        apply(mk_idle(4'd0));
        apply(mk_idle(4'd0));
        apply(mk_lk(12'hABC, 1'b0, 3'd0, 32'hDEAD_BEEF, 4'd0));
        apply(mk_idle(4'd0));

        // Fill everything, then flush with a simultaneous write of idx6.
        for (int i = 0; i < 8; i++)
            apply(mk_wr(3'(i), 12'(256 + i), 32'(4096 + i), 4'(i)));
        r = mk_wr(3'd6, 12'h200, 32'h66, 4'd8);
        r.flush = 1'b1;
        apply(r);
        apply(mk_lk(12'h200, 1'b1, 3'd6, 32'h66, 4'd1));
        for (int i = 0; i < 8; i++)
            apply(mk_lk(12'(256 + i), 1'b0, 3'd0, 32'hDEAD_BEEF, 4'd1));
        apply(mk_idle(4'd1));

        // Asynchronous reset while a response is pending.
        apply(mk_lk(12'h200, 1'b1, 3'd6, 32'h66, 4'd1));
        lk_valid  = 1'b0;
        rsp_ready = 1'b0;
        #1;
        chk("pending_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_occupancy", 32'(occupancy), 32'd0);
        chk("async_rst_lk_ready", 32'(lk_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        apply(mk_lk(12'h200, 1'b0, 3'd0, 32'hDEAD_BEEF, 4'd0));
        apply(mk_idle(4'd0));

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
